// File: rtl/memory_arbiter_pkg.sv
// Shared types for the RAM arbiter: word type, RAM handshake state and arbiter FSM states.
package memory_arbiter_pkg;
  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

  typedef enum logic [2:0] {IDLE, DACC, IACC, RETRY, SCFAIL} arb_state_t;
endpackage

// File: rtl/memory_arbiter_if.sv
// Port bundle between datapath requesters, the arbiter and the RAM model.
interface memory_arbiter_if;
  import memory_arbiter_pkg::*;

  logic      iREN;
  word_t     iaddr;
  logic      dREN;
  logic      dWEN;
  logic      datomic;
  word_t     daddr;
  word_t     dstore;
  logic      iwait;
  logic      dwait;
  word_t     iload;
  word_t     dload;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  modport arb (
    input  iREN, iaddr, dREN, dWEN, datomic, daddr, dstore, ramload, ramstate,
    output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport dp (
    output iREN, iaddr, dREN, dWEN, datomic, daddr, dstore,
    input  iwait, dwait, iload, dload
  );

  modport ram (
    input  ramREN, ramWEN, ramaddr, ramstore,
    output ramload, ramstate
  );
endinterface

// File: rtl/memory_arbiter_link_reg.sv
// LL/SC link register: armed by a completed LL, dropped by any SC or a plain store to the linked word.
// Updates one cycle after the completing access; sc_ok is combinational on the current address.
module memory_arbiter_link_reg
  import memory_arbiter_pkg::*;
(
  input  logic  clk,
  input  logic  nrst,
  input  logic  ll_done,
  input  logic  sc_done,
  input  logic  wr_done,
  input  word_t addr,
  output logic  sc_ok
);
  logic  link_valid;
  word_t link_addr;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      link_valid <= 1'b0;
      link_addr  <= '0;
    end else if (ll_done) begin
      link_valid <= 1'b1;
      link_addr  <= addr;
    end else if (sc_done || (wr_done && addr == link_addr)) begin
      link_valid <= 1'b0;
    end
  end

  assign sc_ok = link_valid && (link_addr == addr);
endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates instruction fetch and data port onto one RAM; handles ERROR retry and LL/SC.
// Min 2 cycles request to wait-low; requesters stall on iwait/dwait until their access completes.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int DSTREAK_MAX = 4
) (
  input logic              CLK,
  input logic              nRST,
  memory_arbiter_if.arb    bus
);
  localparam logic [2:0] DMAX = 3'(DSTREAK_MAX);

  arb_state_t state;
  logic [2:0] dstreak;
  logic       retry_is_data;

  logic wants_data, is_sc, is_ll, data_first, sc_ok;
  logic ram_done, d_done, i_done, scfail_done;

  assign wants_data  = bus.dREN | bus.dWEN;
  assign is_sc       = bus.dWEN & bus.datomic;
  assign is_ll       = bus.dREN & ~bus.dWEN & bus.datomic;
  assign data_first  = wants_data && !(bus.iREN && dstreak == DMAX);
  // A completion seen while reset is asserted is discarded.
  assign ram_done    = (bus.ramstate == ACCESS) && nRST;
  assign d_done      = (state == DACC) && ram_done;
  assign i_done      = (state == IACC) && ram_done;
  assign scfail_done = (state == SCFAIL) && nRST;

  memory_arbiter_link_reg u_link (
    .clk     (CLK),
    .nrst    (nRST),
    .ll_done (d_done & is_ll),
    .sc_done ((d_done & is_sc) | scfail_done),
    .wr_done (d_done & bus.dWEN & ~bus.datomic),
    .addr    (bus.daddr),
    .sc_ok   (sc_ok)
  );

  always_comb begin
    bus.iwait    = 1'b1;
    bus.dwait    = 1'b1;
    bus.iload    = '0;
    bus.dload    = '0;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    case (state)
      DACC: begin
        bus.ramaddr  = bus.daddr;
        bus.ramREN   = bus.dREN & ~bus.dWEN;
        bus.ramWEN   = bus.dWEN;
        bus.ramstore = bus.dstore;
        if (d_done) begin
          bus.dwait = 1'b0;
          bus.dload = is_sc ? word_t'(1) : bus.ramload;
        end
      end
      IACC: begin
        bus.ramaddr = bus.iaddr;
        bus.ramREN  = 1'b1;
        if (i_done) begin
          bus.iwait = 1'b0;
          bus.iload = bus.ramload;
        end
      end
      SCFAIL: begin
        if (nRST) bus.dwait = 1'b0;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state         <= IDLE;
      dstreak       <= '0;
      retry_is_data <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (data_first) state <= (is_sc && !sc_ok) ? SCFAIL : DACC;
          else if (bus.iREN) state <= IACC;
        end
        DACC: begin
          if (bus.ramstate == ACCESS) begin
            state <= IDLE;
            if (!bus.iREN) dstreak <= '0;
            else if (dstreak != DMAX) dstreak <= dstreak + 3'd1;
          end else if (bus.ramstate == ERROR) begin
            state         <= RETRY;
            retry_is_data <= 1'b1;
          end
        end
        IACC: begin
          if (bus.ramstate == ACCESS) begin
            state   <= IDLE;
            dstreak <= '0;
          end else if (bus.ramstate == ERROR) begin
            state         <= RETRY;
            retry_is_data <= 1'b0;
          end
        end
        RETRY:   state <= retry_is_data ? DACC : IACC;
        SCFAIL:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a latency/error-injecting RAM model.
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  logic clk;
  logic nrst;
  memory_arbiter_if mif();

  memory_arbiter #(.DSTREAK_MAX(4)) dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: lat BUSY cycles then ACCESS; one ERROR per armed err_req.
  word_t     mem [0:1023];
  int        lat = 0;
  int        cnt = 0;
  int        err_req = 0;
  int        err_seen = 0;
  ramstate_t rs;

  always_comb begin
    if (!(mif.ramREN || mif.ramWEN)) rs = FREE;
    else if (cnt < lat)              rs = BUSY;
    else if (err_req > err_seen)     rs = ERROR;
    else                             rs = ACCESS;
  end
  assign mif.ramstate = rs;
  assign mif.ramload  = mem[mif.ramaddr[11:2]];

  always @(posedge clk) begin
    cnt <= ((mif.ramREN || mif.ramWEN) && rs == BUSY) ? cnt + 1 : 0;
    if (rs == ERROR) err_seen <= err_seen + 1;
    if (mif.ramWEN && rs == ACCESS) mem[mif.ramaddr[11:2]] = mif.ramstore;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Starts at posedge+1 with the arbiter idle; holds the request until the cycle after dwait drops.
  task automatic data_req(input logic rd, input logic wr, input logic at, input word_t a, input word_t s,
                          output word_t ld, output int cyc, output int wen_n, output int off_n);
    mif.dREN = rd; mif.dWEN = wr; mif.datomic = at; mif.daddr = a; mif.dstore = s;
    ld = 'x; cyc = 0; wen_n = 0; off_n = 0;
    for (int k = 1; k <= 50; k++) begin
      @(posedge clk); #1;
      if (mif.ramWEN) wen_n++;
      if (!mif.ramREN && !mif.ramWEN) off_n++;
      if (!mif.dwait) begin
        cyc = k;
        ld  = mif.dload;
        break;
      end
    end
    @(posedge clk); #1;
    mif.dREN = 1'b0; mif.dWEN = 1'b0; mif.datomic = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  word_t ld, ilast, dlast;
  int    cyc, wn, off;
  int    iw_n, ren_n, first_k, nd, d_before_i, both_low, spur;
  logic  drop_i, i_seen, done;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[32'h40  >> 2] = 32'h8C220004;
    mem[32'h100 >> 2] = 32'hABCD0001;
    mem[32'h200 >> 2] = 32'h12345678;
    mif.iREN = 1'b0; mif.iaddr = '0; mif.dREN = 1'b0; mif.dWEN = 1'b0;
    mif.datomic = 1'b0; mif.daddr = '0; mif.dstore = '0;
    nrst = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_iwait",   32'(mif.iwait),  32'd1);
    check("rst_dwait",   32'(mif.dwait),  32'd1);
    check("rst_ramREN",  32'(mif.ramREN), 32'd0);
    check("rst_ramWEN",  32'(mif.ramWEN), 32'd0);
    check("rst_ramaddr", mif.ramaddr,     32'd0);
    check("rst_iload",   mif.iload,       32'd0);
    check("rst_dload",   mif.dload,       32'd0);
    nrst = 1'b1;

    // Single fetch with two BUSY cycles
    lat = 2; iw_n = 0; ren_n = 0; first_k = 0; drop_i = 1'b0; ilast = '0;
    mif.iaddr = 32'h40; mif.iREN = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (drop_i) begin mif.iREN = 1'b0; drop_i = 1'b0; #1; end
      if (mif.ramREN) ren_n++;
      if (!mif.iwait) begin
        iw_n++; ilast = mif.iload; first_k = k; drop_i = 1'b1;
      end
    end
    check("fetch_iwait_cnt", 32'(iw_n),    32'd1);
    check("fetch_ren_cyc",   32'(ren_n),   32'd3);
    check("fetch_latency",   32'(first_k), 32'd3);
    check("fetch_iload",     ilast,        32'h8C220004);

    // Contention: data wins DSTREAK_MAX times, then one fetch
    lat = 1; nd = 0; d_before_i = -1; both_low = 0; i_seen = 1'b0; drop_i = 1'b0; done = 1'b0;
    ilast = '0; dlast = '0;
    mif.iaddr = 32'h40; mif.iREN = 1'b1; mif.daddr = 32'h200; mif.dREN = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (drop_i) begin mif.iREN = 1'b0; drop_i = 1'b0; #1; end
      if (!mif.dwait && !mif.iwait) both_low++;
      if (!mif.dwait) begin
        nd++; dlast = mif.dload;
        if (i_seen) begin done = 1'b1; break; end
      end
      if (!mif.iwait) begin
        d_before_i = nd; i_seen = 1'b1; ilast = mif.iload; drop_i = 1'b1;
      end
    end
    @(posedge clk); #1;
    mif.dREN = 1'b0;
    check("cont_done",       32'(done),       32'd1);
    check("cont_d_before_i", 32'(d_before_i), 32'd4);
    check("cont_both_low",   32'(both_low),   32'd0);
    check("cont_iload",      ilast,           32'h8C220004);
    check("cont_dload",      dlast,           32'h12345678);

    // LL/SC success, then a second SC on the consumed link
    lat = 0;
    data_req(1'b1, 1'b0, 1'b1, 32'h100, 32'h0, ld, cyc, wn, off);
    check("ll_dload",   ld,         32'hABCD0001);
    check("ll_latency", 32'(cyc),   32'd1);
    data_req(1'b0, 1'b1, 1'b1, 32'h100, 32'h5, ld, cyc, wn, off);
    check("sc_ok_dload", ld,                    32'd1);
    check("sc_ok_wen",   32'(wn),               32'd1);
    check("sc_ok_mem",   mem[32'h100 >> 2],     32'h5);
    data_req(1'b0, 1'b1, 1'b1, 32'h100, 32'h6, ld, cyc, wn, off);
    check("sc2_dload", ld,                32'd0);
    check("sc2_wen",   32'(wn),           32'd0);
    check("sc2_cyc",   32'(cyc),          32'd1);
    check("sc2_mem",   mem[32'h100 >> 2], 32'h5);

    // Plain store to the linked word breaks the link
    data_req(1'b1, 1'b0, 1'b1, 32'h100, 32'h0, ld, cyc, wn, off);
    check("ll2_dload", ld, 32'h5);
    data_req(1'b0, 1'b1, 1'b0, 32'h100, 32'h7, ld, cyc, wn, off);
    data_req(1'b0, 1'b1, 1'b1, 32'h100, 32'h9, ld, cyc, wn, off);
    check("scfail_dload", ld,                32'd0);
    check("scfail_cyc",   32'(cyc),          32'd1);
    check("scfail_wen",   32'(wn),           32'd0);
    check("scfail_off",   32'(off),          32'd1);
    check("scfail_mem",   mem[32'h100 >> 2], 32'h7);

    // Store to a different word leaves the link intact
    data_req(1'b1, 1'b0, 1'b1, 32'h300, 32'h0,  ld, cyc, wn, off);
    data_req(1'b0, 1'b1, 1'b0, 32'h304, 32'h11, ld, cyc, wn, off);
    data_req(1'b0, 1'b1, 1'b1, 32'h300, 32'h22, ld, cyc, wn, off);
    check("other_sc_dload", ld,                32'd1);
    check("other_sc_mem",   mem[32'h300 >> 2], 32'h22);
    check("other_sw_mem",   mem[32'h304 >> 2], 32'h11);

    // ERROR on first attempt: one idle RETRY cycle, then reissue
    err_req = err_seen + 1;
    data_req(1'b1, 1'b0, 1'b0, 32'h200, 32'h0, ld, cyc, wn, off);
    check("retry_dload", ld,        32'h12345678);
    check("retry_cyc",   32'(cyc),  32'd3);
    check("retry_off",   32'(off),  32'd1);

    // Reset in the middle of a BUSY data access
    data_req(1'b1, 1'b0, 1'b1, 32'h100, 32'h0, ld, cyc, wn, off);
    lat = 5;
    mif.dREN = 1'b1; mif.daddr = 32'h200;
    repeat (2) begin @(posedge clk); #1; end
    check("mid_ramREN", 32'(mif.ramREN), 32'd1);
    nrst = 1'b0;
    @(posedge clk); #1;
    check("rstmid_ramREN", 32'(mif.ramREN), 32'd0);
    check("rstmid_ramWEN", 32'(mif.ramWEN), 32'd0);
    check("rstmid_dwait",  32'(mif.dwait),  32'd1);
    mif.dREN = 1'b0;
    nrst = 1'b1;
    spur = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (!mif.dwait || !mif.iwait) spur++;
    end
    check("rstmid_spurious", 32'(spur), 32'd0);
    lat = 0;
    data_req(1'b0, 1'b1, 1'b1, 32'h100, 32'h3, ld, cyc, wn, off);
    check("rstmid_sc_dload", ld,                32'd0);
    check("rstmid_sc_mem",   mem[32'h100 >> 2], 32'h7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
